aes_inv_fsm_controller: RTL and testbench

Control FSM for the AES-128 decryption (inverse cipher) datapath, the counterpart to the encryption controller. It sequences key expansion, AddRoundKey, InvShiftRows, InvSubBytes and InvMixColumns, issuing round keys in descending order (10 down to 0). It sits beside the inverse datapath and the shared key-schedule block, drives their enables, and reports `done`, `busy` and `err` to the host.

---
 rtl/aes_ctrl_pkg.sv | 20 ++
 rtl/aes_wdog_timer.sv | 31 +++
 rtl/aes_inv_fsm_controller.sv | 125 ++++++++++++
 tb/tb_aes_inv_fsm_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : aes_ctrl_pkg
// Brief    : Shared constants for the AES control FSMs (state codes, NR).
// Revision : 1.0
// ----------------------------------------------------------------------------
package aes_ctrl_pkg;
  localparam int C_NR    = 10;
  localparam int C_RND_W = 4;

  localparam logic [2:0] C_S_IDLE       = 3'd0;
  localparam logic [2:0] C_S_KEY_EXPAND = 3'd1;
  localparam logic [2:0] C_S_ARK        = 3'd2;
  localparam logic [2:0] C_S_INV_SR     = 3'd3;
  localparam logic [2:0] C_S_INV_SB     = 3'd4;
  localparam logic [2:0] C_S_INV_MC     = 3'd5;
  localparam logic [2:0] C_S_DONE       = 3'd6;
  localparam logic [2:0] C_S_ERR        = 3'd7;
endpackage
`default_nettype wire

// File: rtl/aes_wdog_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : aes_wdog_timer
// Brief    : Saturating dwell counter; expired flags the last permitted cycle.
// Revision : 1.0
// ----------------------------------------------------------------------------
module aes_wdog_timer #(
  parameter int WDOG_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int C_W = $clog2(WDOG_CYCLES + 1);

  logic [C_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != C_W'(WDOG_CYCLES))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt counts completed cycles, so this is the WDOG_CYCLES-th cycle in state
  assign expired = en && (r_cnt >= C_W'(WDOG_CYCLES - 1));
endmodule
`default_nettype wire

// File: rtl/aes_inv_fsm_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : aes_inv_fsm_controller
// Brief    : AES-128 inverse-cipher sequencer with descending round keys.
// Revision : 1.0
// ----------------------------------------------------------------------------
module aes_inv_fsm_controller
  import aes_ctrl_pkg::*;
#(
  parameter int NR          = C_NR,
  parameter int WDOG_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ks_ready,
  input  logic               isb_done,
  output logic               load_en,
  output logic               ks_en,
  output logic               ark_en,
  output logic               isr_en,
  output logic               isb_clr,
  output logic               isb_en,
  output logic               imc_en,
  output logic [C_RND_W-1:0] round,
  output logic               busy,
  output logic               done,
  output logic               err
);
  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [C_RND_W-1:0] r_round;
  logic               w_expired;
  logic               w_wd_clr;
  logic               w_wd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= C_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_round <= '0;
    end else if ((r_state == C_S_IDLE) && start) begin
      r_round <= C_RND_W'(NR);
    end else if (w_next == C_S_ERR) begin
      r_round <= '0;
    end else if ((r_state == C_S_ARK) && (r_round != '0)) begin
      r_round <= r_round - 1'b1;
    end
  end

  // ARK routing uses the round value on entry (before its decrement)
  always_comb begin
    w_next = r_state;
    case (r_state)
      C_S_IDLE:       if (start) w_next = C_S_KEY_EXPAND;
      C_S_KEY_EXPAND: begin
        if (ks_ready)       w_next = C_S_ARK;
        else if (w_expired) w_next = C_S_ERR;
      end
      C_S_ARK: begin
        if (r_round == '0)                   w_next = C_S_DONE;
        else if (r_round == C_RND_W'(NR))    w_next = C_S_INV_SR;
        else                                 w_next = C_S_INV_MC;
      end
      C_S_INV_SR:     w_next = C_S_INV_SB;
      C_S_INV_SB: begin
        if (isb_done)       w_next = C_S_ARK;
        else if (w_expired) w_next = C_S_ERR;
      end
      C_S_INV_MC:     w_next = C_S_INV_SR;
      C_S_DONE:       w_next = C_S_IDLE;
      C_S_ERR:        w_next = C_S_IDLE;
      default:        w_next = C_S_IDLE;
    endcase
  end

  always_comb begin
    load_en = 1'b0;
    ks_en   = 1'b0;
    ark_en  = 1'b0;
    isr_en  = 1'b0;
    isb_clr = 1'b0;
    isb_en  = 1'b0;
    imc_en  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    case (r_state)
      C_S_IDLE:       load_en = start;
      C_S_KEY_EXPAND: ks_en   = 1'b1;
      C_S_ARK:        ark_en  = 1'b1;
      C_S_INV_SR: begin
        isr_en  = 1'b1;
        isb_clr = 1'b1;
      end
      C_S_INV_SB:     isb_en  = ~isb_done;
      C_S_INV_MC:     imc_en  = 1'b1;
      C_S_DONE:       done    = 1'b1;
      C_S_ERR:        err     = 1'b1;
      default:        load_en = 1'b0;
    endcase
  end

  assign busy  = (r_state != C_S_IDLE);
  assign round = r_round;

  assign w_wd_clr = (w_next != r_state);
  assign w_wd_en  = (r_state == C_S_KEY_EXPAND) || (r_state == C_S_INV_SB);

  aes_wdog_timer #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_expired)
  );
endmodule
`default_nettype wire

// File: tb/tb_aes_inv_fsm_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_aes_inv_fsm_controller
// Brief    : Randomised bench for the inverse-cipher controller against an
//            operation-list reference model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_aes_inv_fsm_controller;
  localparam int C_WDOG = 64;
  localparam int C_NOPS = 42;
  localparam int OP_KE = 0, OP_ARK = 1, OP_ISR = 2, OP_ISB = 3, OP_IMC = 4, OP_DONE = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ks_ready = 1'b0;
  logic       isb_done = 1'b0;
  logic       load_en, ks_en, ark_en, isr_en, isb_clr, isb_en, imc_en;
  logic [3:0] round;
  logic       busy, done, err;

  aes_inv_fsm_controller #(.NR(10), .WDOG_CYCLES(C_WDOG)) dut (
    .clk(clk), .rst(rst), .start(start), .ks_ready(ks_ready), .isb_done(isb_done),
    .load_en(load_en), .ks_en(ks_en), .ark_en(ark_en), .isr_en(isr_en),
    .isb_clr(isb_clr), .isb_en(isb_en), .imc_en(imc_en), .round(round),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the decryption is a fixed list of operations; each entry
  // carries the round index visible on the round output during that step.
  int op_code [C_NOPS];
  int op_rnd  [C_NOPS];
  int m_pos = -1;            // -1 idle, -2 error pulse, else index into list
  int m_cyc = 0;             // cycles already spent in current op
  int m_idle_round = 0;

  task automatic build_ops();
    int n = 0;
    op_code[n] = OP_KE;  op_rnd[n] = 10; n++;
    op_code[n] = OP_ARK; op_rnd[n] = 10; n++;
    for (int r = 9; r >= 1; r--) begin
      op_code[n] = OP_ISR; op_rnd[n] = r;     n++;
      op_code[n] = OP_ISB; op_rnd[n] = r;     n++;
      op_code[n] = OP_ARK; op_rnd[n] = r;     n++;
      op_code[n] = OP_IMC; op_rnd[n] = r - 1; n++;
    end
    op_code[n] = OP_ISR;  op_rnd[n] = 0; n++;
    op_code[n] = OP_ISB;  op_rnd[n] = 0; n++;
    op_code[n] = OP_ARK;  op_rnd[n] = 0; n++;
    op_code[n] = OP_DONE; op_rnd[n] = 0;
  endtask

  // bits: 13 load 12 ks 11 ark 10 isr 9 isbclr 8 isben 7 imc 6 busy 5 done 4 err 3:0 round
  function automatic logic [13:0] model_out(input logic st, input logic isbd);
    logic [13:0] e;
    e = '0;
    if (m_pos == -1) begin
      e[13]  = st;
      e[3:0] = 4'(m_idle_round);
    end else if (m_pos == -2) begin
      e[6] = 1'b1;
      e[4] = 1'b1;
    end else begin
      e[6]   = 1'b1;
      e[3:0] = 4'(op_rnd[m_pos]);
      case (op_code[m_pos])
        OP_KE:   e[12] = 1'b1;
        OP_ARK:  e[11] = 1'b1;
        OP_ISR:  begin e[10] = 1'b1; e[9] = 1'b1; end
        OP_ISB:  e[8] = ~isbd;
        OP_IMC:  e[7] = 1'b1;
        OP_DONE: e[5] = 1'b1;
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  task automatic model_update();
    logic hs;
    if (rst) begin
      m_pos = -1; m_idle_round = 0;
    end else if (m_pos == -1) begin
      if (start) begin m_pos = 0; m_cyc = 0; end
    end else if (m_pos == -2) begin
      m_pos = -1; m_idle_round = 0;
    end else if (op_code[m_pos] == OP_DONE) begin
      m_pos = -1; m_idle_round = 0;
    end else if (op_code[m_pos] == OP_KE || op_code[m_pos] == OP_ISB) begin
      hs = (op_code[m_pos] == OP_KE) ? ks_ready : isb_done;
      if (hs) begin
        m_pos++; m_cyc = 0;
      end else if (m_cyc + 1 >= C_WDOG) begin
        m_pos = -2; m_cyc = 0;
      end else begin
        m_cyc++;
      end
    end else begin
      m_pos++; m_cyc = 0;
    end
  endtask

  // Observed statistics, measured relative to the last load_en cycle
  int cyc_no = 0, lat = 0, imc_n = 0, isr_n = 0, ark_n = 0, isben_n = 0;
  int done_total = 0, err_total = 0, load_total = 0;
  int done_lat = -1, err_lat = -1, prev_load = -1, last_load = -1;
  int rnd_p = 4;
  logic [13:0] last_got;

  // hs: 0 tied high, 1 nominal K=4/S=16, 2 ks high + isb stuck low, 3 random
  task automatic step(input logic st, input logic do_rst, input int hs);
    int op;
    logic [13:0] exp;
    @(negedge clk);
    rst   = do_rst;
    start = st;
    op = (m_pos >= 0) ? op_code[m_pos] : -1;
    case (hs)
      0: begin ks_ready = 1'b1; isb_done = 1'b1; end
      1: begin
        ks_ready = (op == OP_KE)  && (m_cyc >= 3);
        isb_done = (op == OP_ISB) && (m_cyc >= 15);
      end
      2: begin ks_ready = 1'b1; isb_done = 1'b0; end
      default: begin
        ks_ready = ($urandom_range(0, rnd_p - 1) == 0);
        isb_done = ($urandom_range(0, rnd_p - 1) == 0);
      end
    endcase
    #1;
    exp = model_out(start, isb_done);
    last_got = {load_en, ks_en, ark_en, isr_en, isb_clr, isb_en, imc_en,
                busy, done, err, round};
    check("outputs", 32'(last_got), 32'(exp));
    if (last_got[13]) begin
      lat = 0; imc_n = 0; isr_n = 0; ark_n = 0; isben_n = 0;
      load_total++; prev_load = last_load; last_load = cyc_no;
    end else begin
      lat++;
    end
    if (last_got[7])  imc_n++;
    if (last_got[10]) isr_n++;
    if (last_got[11]) ark_n++;
    if (last_got[8])  isben_n++;
    if (last_got[5]) begin done_total++; done_lat = lat; end
    if (last_got[4]) begin err_total++;  err_lat  = lat; end
    @(posedge clk);
    model_update();
    cyc_no++;
  endtask

  task automatic run_to_done(input int hs, input int budget);
    int d0 = done_total;
    int k = 0;
    while (done_total == d0 && k < budget) begin
      step(1'b0, 1'b0, hs);
      k++;
    end
    if (done_total == d0) check("done_timeout", 0, 1);
  endtask

  initial begin
    int d0, e0, l0, k;
    build_ops();

    step(1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 0);
    check("reset_outs", 32'(last_got), 0);

    // Nominal K=4, S=16
    step(1'b1, 1'b0, 1);
    run_to_done(1, 400);
    check("nom_latency", done_lat, 195);
    check("nom_imc", imc_n, 9);
    check("nom_isr", isr_n, 10);
    check("nom_ark", ark_n, 11);

    // Minimum latency
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    run_to_done(0, 100);
    check("min_latency", done_lat, 42);
    check("min_isben", isben_n, 0);

    // start held high: reload exactly one idle cycle after done
    step(1'b0, 1'b0, 0);
    l0 = load_total;
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 0);
    check("held_loads", load_total - l0, 2);
    check("held_gap", last_load - prev_load, 43);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 0);

    // Reset during the round-5 InvSubBytes visit
    step(1'b1, 1'b0, 1);
    k = 0;
    while (!(m_pos >= 0 && op_code[m_pos] == OP_ISB && op_rnd[m_pos] == 5) && k < 400) begin
      step(1'b0, 1'b0, 1);
      k++;
    end
    check("rst_reach", (k < 400) ? 1 : 0, 1);
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 1);
    check("rst_mid_outs", 32'(last_got), 0);
    step(1'b1, 1'b0, 1);
    run_to_done(1, 400);
    check("rst_rerun_latency", done_lat, 195);

    // Watchdog on a stuck InvSubBytes
    step(1'b0, 1'b0, 0);
    d0 = done_total; e0 = err_total;
    step(1'b1, 1'b0, 2);
    for (int i = 0; i < 150; i++) step(1'b0, 1'b0, 2);
    check("wdog_err_count", err_total - e0, 1);
    check("wdog_err_lat", err_lat, 68);
    check("wdog_no_done", done_total - d0, 0);

    // Randomised traffic with varying handshake rates and rare resets
    for (int blk = 0; blk < 16; blk++) begin
      case (blk % 4)
        0: rnd_p = 1;
        1: rnd_p = 4;
        2: rnd_p = 12;
        default: rnd_p = 40;
      endcase
      for (int i = 0; i < 250; i++)
        step(($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0), 3);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
